// File: rtl/peridot_csr_swi_flashid.sv
`timescale 1ns/1ps
// SPI-flash ID sequencer: sends preamble, command and dummy bytes, reads DATA_BYTES bytes, then reduces them into id_data.
// Latency: at least 3 cycles per byte (WAIT, WRITE, GAP); id_valid rises 2 cycles after the final ready poll.
// Backpressure: stalls in WAIT while peripheral ready is low; after TIMEOUT_CYCLES it aborts the run with id_error.

module peridot_csr_swi_flashid #(
    parameter logic [7:0] FLASH_COMMAND  = 8'h4b,
    parameter int         DUMMY_BYTES    = 4,
    parameter int         DATA_BYTES     = 16,
    parameter int         OUT_WIDTH      = 64,
    parameter int         FOLD_MODE      = 1,
    parameter int         AUTOSTART      = 1,
    parameter int         TIMEOUT_CYCLES = 65535
) (
    input  logic                 clock_sig,
    input  logic                 reset_sig,
    input  logic [31:0]          flash_readdata,
    output logic                 flash_write,
    output logic [31:0]          flash_writedata,
    input  logic                 start,
    output logic                 busy,
    output logic [OUT_WIDTH-1:0] id_data,
    output logic                 id_valid,
    output logic                 id_error
);

    // Transfer indices: 0 = CS-release preamble, 1 = command, then dummies, then data up to T_LAST.
    localparam int               LAST_XFER   = 1 + DUMMY_BYTES + DATA_BYTES;
    localparam logic [5:0]       T_LAST      = 6'(LAST_XFER);
    // The byte received during transfer t-1 is sampled before issuing t; the first data byte is t = 2+DUMMY.
    localparam logic [5:0]       T_FIRST_CAP = 6'(3 + DUMMY_BYTES);
    localparam int               CNT_W       = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO_LIMIT   = CNT_W'(TIMEOUT_CYCLES);
    localparam bit               TMO_EN      = (TIMEOUT_CYCLES != 0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_WRITE = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [5:0]           idx_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [OUT_WIDTH-1:0] id_q, id_next;
    logic                 id_valid_q, id_error_q;
    logic                 wr_q;
    logic [31:0]          wd_q;
    logic                 auto_q;

    // Decoded actions for the datapath, produced by the next-state logic.
    logic                 launch, capture, issue, timeout, finish;

    logic                 ready;
    logic [7:0]           rx_byte;
    logic [7:0]           tx_byte;
    logic                 tx_cs;
    logic [31:0]          tx_word;
    logic                 unused_readdata;

    assign ready           = flash_readdata[9];
    assign rx_byte         = flash_readdata[7:0];
    assign unused_readdata = ^{flash_readdata[31:10], flash_readdata[8]};

    assign busy            = (state_q != S_IDLE);
    assign flash_write     = wr_q;
    assign flash_writedata = wd_q;
    assign id_data         = id_q;
    assign id_valid        = id_valid_q;
    assign id_error        = id_error_q;

    // Control word for the current transfer index; CS drops on the preamble and on the last data byte.
    always_comb begin
        tx_byte = (idx_q == 6'd1) ? FLASH_COMMAND : 8'h00;
        tx_cs   = (idx_q != 6'd0) && (idx_q < T_LAST);
        tx_word = {22'd0, 1'b1, tx_cs, tx_byte};
    end

    // Identifier reduction of one received byte: XOR-rotate fold or plain shift-in.
    always_comb begin
        if (FOLD_MODE != 0) begin
            id_next = {id_q[OUT_WIDTH-9:0], id_q[OUT_WIDTH-1:OUT_WIDTH-8] ^ rx_byte};
        end else begin
            id_next = {id_q[OUT_WIDTH-9:0], rx_byte};
        end
    end

    // State register.
    always_ff @(posedge clock_sig or posedge reset_sig) begin
        if (reset_sig) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and per-cycle action decode.
    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        capture = 1'b0;
        issue   = 1'b0;
        timeout = 1'b0;
        finish  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start || auto_q) begin
                    launch  = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (ready) begin
                    capture = (idx_q >= T_FIRST_CAP);
                    if (idx_q <= T_LAST) begin
                        issue   = 1'b1;
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (TMO_EN && (cnt_q == TMO_LIMIT)) begin
                    timeout = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_WRITE: state_d = S_GAP;
            S_GAP:   state_d = S_WAIT;
            S_DONE: begin
                finish  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // One-shot autostart request, armed by reset and consumed on the first cycle after release.
    always_ff @(posedge clock_sig or posedge reset_sig) begin
        if (reset_sig) begin
            auto_q <= (AUTOSTART != 0);
        end else begin
            auto_q <= 1'b0;
        end
    end

    // Transfer index and per-byte ready timeout counter.
    always_ff @(posedge clock_sig or posedge reset_sig) begin
        if (reset_sig) begin
            idx_q <= 6'd0;
            cnt_q <= '0;
        end else if (launch) begin
            idx_q <= 6'd0;
            cnt_q <= '0;
        end else if (state_q == S_WRITE) begin
            idx_q <= idx_q + 6'd1;
            cnt_q <= '0;
        end else if (state_q == S_WAIT) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Peripheral write strobe and held control word; the word keeps its last value between writes.
    always_ff @(posedge clock_sig or posedge reset_sig) begin
        if (reset_sig) begin
            wr_q <= 1'b0;
            wd_q <= 32'h0000_0200;
        end else begin
            wr_q <= issue;
            if (issue) begin
                wd_q <= tx_word;
            end
        end
    end

    // Identifier accumulator and status flags; cleared when a run is launched.
    always_ff @(posedge clock_sig or posedge reset_sig) begin
        if (reset_sig) begin
            id_q       <= '0;
            id_valid_q <= 1'b0;
            id_error_q <= 1'b0;
        end else if (launch) begin
            id_q       <= '0;
            id_valid_q <= 1'b0;
            id_error_q <= 1'b0;
        end else begin
            if (capture) begin
                id_q <= id_next;
            end
            if (timeout) begin
                id_error_q <= 1'b1;
            end
            if (finish) begin
                id_valid_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_peridot_csr_swi_flashid.sv
`timescale 1ns/1ps
// Bench for peridot_csr_swi_flashid: three configurations, each with its own peripheral model.
// Fixed vectors and hand sequences cover timing, timeout, start/reset corners; random runs use a reference model.
// Every write is checked against the expected control word for its transfer index.

module tb_peridot_csr_swi_flashid;

    localparam int         NI      = 3;
    localparam logic [7:0] CMD     = 8'h4B;
    // Per-instance configuration: u0 defaults (short timeout), u1 raw capture, u2 minimal.
    localparam int         D_OF[NI] = '{4, 4, 0};
    localparam int         B_OF[NI] = '{16, 16, 1};
    localparam int         W_OF[NI] = '{64, 64, 32};
    localparam int         F_OF[NI] = '{1, 0, 1};

    logic        clock_sig = 1'b0;
    logic        reset_sig = 1'b1;
    logic [31:0] rd   [NI];
    logic        fw   [NI];
    logic [31:0] fwd  [NI];
    logic        st   [NI] = '{1'b0, 1'b0, 1'b0};
    logic        bsy  [NI];
    logic        idv  [NI];
    logic        ide  [NI];
    logic [63:0] id0, id1;
    logic [31:0] id2;

    // Peripheral model state.
    logic [7:0]  dat  [NI][32];
    logic [7:0]  rx   [NI];
    logic        rnd  [NI];
    int          rstall [NI];
    int          widx [NI];
    int          rmode [NI] = '{0, 0, 0};   // 0 ready high, 1 random ready, 2 ready stuck low from transfer 6
    int          wtot [NI] = '{0, 0, 0};

    int checks = 0;
    int errors = 0;

    always #5 clock_sig = ~clock_sig;

    peridot_csr_swi_flashid #(.TIMEOUT_CYCLES(16)) u0 (
        .clock_sig(clock_sig), .reset_sig(reset_sig), .flash_readdata(rd[0]),
        .flash_write(fw[0]), .flash_writedata(fwd[0]), .start(st[0]),
        .busy(bsy[0]), .id_data(id0), .id_valid(idv[0]), .id_error(ide[0]));

    peridot_csr_swi_flashid #(.FOLD_MODE(0)) u1 (
        .clock_sig(clock_sig), .reset_sig(reset_sig), .flash_readdata(rd[1]),
        .flash_write(fw[1]), .flash_writedata(fwd[1]), .start(st[1]),
        .busy(bsy[1]), .id_data(id1), .id_valid(idv[1]), .id_error(ide[1]));

    peridot_csr_swi_flashid #(.DUMMY_BYTES(0), .DATA_BYTES(1), .OUT_WIDTH(32)) u2 (
        .clock_sig(clock_sig), .reset_sig(reset_sig), .flash_readdata(rd[2]),
        .flash_write(fw[2]), .flash_writedata(fwd[2]), .start(st[2]),
        .busy(bsy[2]), .id_data(id2), .id_valid(idv[2]), .id_error(ide[2]));

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Byte the flash returns during transfer t: data bytes in order, filler elsewhere.
    function automatic logic [7:0] rx_for(input int i, input int t);
        int k;
        k = t - (2 + D_OF[i]);
        if (k >= 0 && k < B_OF[i]) return dat[i][k];
        return 8'(8'hC0 + t);
    endfunction

    function automatic logic [31:0] exp_wd(input int i, input int t);
        int n;
        n = 1 + D_OF[i] + B_OF[i];
        if (t == 0) return 32'h0000_0200;
        if (t == 1) return 32'h0000_0300 | {24'd0, CMD};
        if (t < n)  return 32'h0000_0300;
        if (t == n) return 32'h0000_0200;
        return 32'hDEAD_BEEF;
    endfunction

    // Reference identifier: rotate the W-bit word left a byte, then XOR (fold) or replace (raw) the low byte.
    function automatic logic [127:0] ref_id(input int i);
        logic [127:0] r;
        logic [127:0] m;
        int w;
        w = W_OF[i];
        r = '0;
        m = (w == 128) ? '1 : ((128'd1 << w) - 128'd1);
        for (int k = 0; k < B_OF[i]; k++) begin
            if (F_OF[i] != 0) r = (((r << 8) | (r >> (w - 8))) & m) ^ {120'd0, dat[i][k]};
            else              r = ((r << 8) | {120'd0, dat[i][k]}) & m;
        end
        return r;
    endfunction

    function automatic logic [127:0] id_of(input int i);
        case (i)
            0:       return {64'd0, id0};
            1:       return {64'd0, id1};
            default: return {96'd0, id2};
        endcase
    endfunction

    // Peripheral model: receive byte and transfer count advance on each write; ready per rmode.
    always @(posedge clock_sig or posedge reset_sig) begin
        for (int i = 0; i < NI; i++) begin
            if (reset_sig) begin
                widx[i]   <= 0;
                rx[i]     <= 8'h00;
                rnd[i]    <= 1'b1;
                rstall[i] <= 0;
            end else begin
                if (!bsy[i]) widx[i] <= 0;
                else if (fw[i]) begin
                    widx[i] <= widx[i] + 1;
                    rx[i]   <= rx_for(i, widx[i]);
                end
                if (rmode[i] == 1 && rstall[i] < 3 && $urandom_range(0, 3) == 0) begin
                    rnd[i]    <= 1'b0;
                    rstall[i] <= rstall[i] + 1;
                end else begin
                    rnd[i]    <= 1'b1;
                    rstall[i] <= 0;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NI; i++) begin
            rd[i] = {22'd0, (rmode[i] == 0) ? 1'b1 : (rmode[i] == 1) ? rnd[i] : (widx[i] < 6), 1'b0, rx[i]};
        end
    end

    // Write monitor: every strobe carries the control word for its transfer index.
    always @(negedge clock_sig) begin
        for (int i = 0; i < NI; i++) begin
            if (fw[i] === 1'b1) begin
                chk($sformatf("u%0d write t=%0d", i, widx[i]), {96'd0, fwd[i]}, {96'd0, exp_wd(i, widx[i])});
                wtot[i] = wtot[i] + 1;
            end
        end
    end

    task automatic pulse_start(input int i);
        @(negedge clock_sig) st[i] = 1'b1;
        @(negedge clock_sig) st[i] = 1'b0;
    endtask

    task automatic wait_valid(input int i, input int budget, output int cyc);
        cyc = -1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clock_sig);
            if (idv[i]) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic wait_widx(input int i, input int t, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clock_sig);
            if (widx[i] == t) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_reset_vals(input int i, input string nm);
        chk({nm, " flash_write"}, {127'd0, fw[i]}, 128'd0);
        chk({nm, " writedata"}, {96'd0, fwd[i]}, 128'h200);
        chk({nm, " busy"}, {127'd0, bsy[i]}, 128'd0);
        chk({nm, " id_data"}, id_of(i), 128'd0);
        chk({nm, " id_valid"}, {127'd0, idv[i]}, 128'd0);
        chk({nm, " id_error"}, {127'd0, ide[i]}, 128'd0);
    endtask

    task automatic do_run(input int i, input logic [127:0] exp_id, input int exp_wr, input string nm);
        int w0, cyc;
        w0 = wtot[i];
        pulse_start(i);
        wait_valid(i, 3000, cyc);
        chk({nm, " completes"}, {127'd0, cyc > 0}, 128'd1);
        chk({nm, " id"}, id_of(i), exp_id);
        chk({nm, " err"}, {127'd0, ide[i]}, 128'd0);
        chk({nm, " busy"}, {127'd0, bsy[i]}, 128'd0);
        chk({nm, " writes"}, 128'(wtot[i] - w0), 128'(exp_wr));
    endtask

    typedef struct {
        int           inst;
        logic [7:0]   base;
        logic [7:0]   step;
        logic [127:0] exp_id;
        int           exp_wr;
    } vec_t;

    initial begin
        vec_t tbl[8];
        int   vc[NI];
        int   cyc, w0, last, ec;
        bit   ok;

        tbl[0] = '{0, 8'h01, 8'h01, 128'h0808080808080818, 22};
        tbl[1] = '{1, 8'h01, 8'h01, 128'h090A0B0C0D0E0F10, 22};
        tbl[2] = '{2, 8'hAB, 8'h00, 128'h000000AB, 3};
        tbl[3] = '{0, 8'hFF, 8'h00, 128'h0, 22};
        tbl[4] = '{1, 8'hFF, 8'h00, 128'hFFFFFFFFFFFFFFFF, 22};
        tbl[5] = '{2, 8'h5A, 8'h00, 128'h0000005A, 3};
        tbl[6] = '{0, 8'h80, 8'h01, 128'h0808080808080808, 22};
        tbl[7] = '{1, 8'h80, 8'h01, 128'h88898A8B8C8D8E8F, 22};

        for (int i = 0; i < NI; i++)
            for (int k = 0; k < 32; k++) dat[i][k] = (i == 2) ? ((k == 0) ? 8'hAB : 8'h00) : 8'(k + 1);

        // Reset values while reset is held.
        repeat (3) @(negedge clock_sig);
        for (int i = 0; i < NI; i++) check_reset_vals(i, $sformatf("u%0d reset", i));

        // Autostart with ready high: valid after 3(N+1)+3 cycles.
        reset_sig = 1'b0;
        vc = '{-1, -1, -1};
        for (int c = 1; c <= 200; c++) begin
            @(negedge clock_sig);
            for (int i = 0; i < NI; i++) if (idv[i] && vc[i] < 0) vc[i] = c;
            if (vc[0] > 0 && vc[1] > 0 && vc[2] > 0) break;
        end
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("u%0d autostart latency", i), 128'(vc[i]), 128'(3 * (2 + D_OF[i] + B_OF[i]) + 3));
            chk($sformatf("u%0d autostart id", i), id_of(i), ref_id(i));
            chk($sformatf("u%0d autostart writes", i), 128'(wtot[i]), 128'(2 + D_OF[i] + B_OF[i]));
        end

        // Fixed vectors.
        for (int v = 0; v < 8; v++) begin
            for (int k = 0; k < 32; k++) dat[tbl[v].inst][k] = tbl[v].base + 8'(k) * tbl[v].step;
            do_run(tbl[v].inst, tbl[v].exp_id, tbl[v].exp_wr, $sformatf("vec%0d", v));
        end

        // Timeout: ready stuck low after transfer 5. Error comes 1 (WRITE->GAP) + 1 (GAP->WAIT) + 17 cycles after the last strobe.
        for (int k = 0; k < 32; k++) dat[0][k] = 8'(k + 1);
        rmode[0] = 2;
        w0 = wtot[0];
        last = -1;
        ec = -1;
        pulse_start(0);
        for (int c = 1; c <= 600; c++) begin
            @(negedge clock_sig);
            if (fw[0]) last = c;
            if (ide[0]) begin
                ec = c;
                break;
            end
        end
        chk("tmo flag", {127'd0, ec > 0}, 128'd1);
        chk("tmo latency", 128'(ec - last), 128'd19);
        chk("tmo busy", {127'd0, bsy[0]}, 128'd0);
        chk("tmo valid", {127'd0, idv[0]}, 128'd0);
        chk("tmo writes", 128'(wtot[0] - w0), 128'd6);
        repeat (30) @(negedge clock_sig);
        chk("tmo no more writes", 128'(wtot[0] - w0), 128'd6);
        chk("tmo flag held", {127'd0, ide[0]}, 128'd1);
        rmode[0] = 0;
        do_run(0, 128'h0808080808080818, 22, "tmo rerun");

        // start during a run is ignored.
        w0 = wtot[0];
        pulse_start(0);
        wait_widx(0, 8, ok);
        chk("midstart reached t8", {127'd0, ok}, 128'd1);
        st[0] = 1'b1;
        @(negedge clock_sig) st[0] = 1'b0;
        wait_valid(0, 500, cyc);
        chk("midstart completes", {127'd0, cyc > 0}, 128'd1);
        repeat (20) @(negedge clock_sig);
        chk("midstart no requeue", {127'd0, bsy[0]}, 128'd0);
        chk("midstart writes", 128'(wtot[0] - w0), 128'd22);
        chk("midstart id", id_of(0), 128'h0808080808080818);

        // start after valid: valid drops the next cycle, identical result follows.
        w0 = wtot[0];
        pulse_start(0);
        chk("restart valid drop", {127'd0, idv[0]}, 128'd0);
        chk("restart busy", {127'd0, bsy[0]}, 128'd1);
        wait_valid(0, 500, cyc);
        chk("restart completes", {127'd0, cyc > 0}, 128'd1);
        chk("restart id", id_of(0), 128'h0808080808080818);
        chk("restart writes", 128'(wtot[0] - w0), 128'd22);

        // Asynchronous reset mid-run, then autostart from the preamble.
        pulse_start(0);
        wait_widx(0, 10, ok);
        chk("rst reached t10", {127'd0, ok}, 128'd1);
        #2 reset_sig = 1'b1;
        #1 check_reset_vals(0, "midrun reset");
        @(negedge clock_sig) reset_sig = 1'b0;
        w0 = wtot[0];
        wait_valid(0, 500, cyc);
        chk("rst restart latency", 128'(cyc), 128'd69);
        chk("rst restart id", id_of(0), 128'h0808080808080818);
        chk("rst restart writes", 128'(wtot[0] - w0), 128'd22);
        repeat (5) @(negedge clock_sig);

        // Random data with random ready stalls against the reference model.
        for (int r = 0; r < 12; r++) begin
            int i;
            i = $urandom_range(0, NI - 1);
            for (int k = 0; k < 32; k++) dat[i][k] = 8'($urandom);
            rmode[i] = 1;
            do_run(i, ref_id(i), 2 + D_OF[i] + B_OF[i], $sformatf("rand%0d u%0d", r, i));
            rmode[i] = 0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/peridot_csr_swi_flashid.md
# peridot_csr_swi_flashid

Parametrised SPI-flash identification sequencer for the PERIDOT SWI CSR block. It drives the SPI peripheral control register directly, one byte per write. Each run sends a configurable read command, then dummy bytes, then reads N data bytes and reduces them into an OUT_WIDTH-bit identifier, either XOR-folded or raw-captured. It adds re-run on demand, a busy flag, and a per-byte ready timeout with an error flag. The output feeds the CSR unique-ID registers and the SWI host-visible ID.

## Interface
Parameters:
- FLASH_COMMAND, 8'h4b, command byte sent at transfer 1.
- DUMMY_BYTES, 4, dummy bytes after the command; range 0..8.
- DATA_BYTES, 16, data bytes read; range 1..32.
- OUT_WIDTH, 64, identifier width; multiple of 8, range 32..128.
- FOLD_MODE, 1, 1 = XOR-rotate fold, 0 = raw shift (keeps the last OUT_WIDTH/8 bytes).
- AUTOSTART, 1, 1 = start one run automatically after reset release.
- TIMEOUT_CYCLES, 65535, maximum cycles spent waiting for ready per byte; 0 disables the timeout.

Ports:
- clock_sig  in  1  clock; all logic is posedge.
- reset_sig  in  1  asynchronous, active-high reset.
- flash_readdata  in  32  peripheral status: bit 9 = ready, bits [7:0] = last received byte.
- flash_write  out  1  one-cycle write strobe to the peripheral.
- flash_writedata  out  32  {22'b0, 1'b1 (start), assert (CS), txbyte[7:0]}.
- start  in  1  single-cycle request to re-run; ignored while busy.
- busy  out  1  a sequence is in progress.
- id_data  out  OUT_WIDTH  identifier result.
- id_valid  out  1  id_data is complete and good.
- id_error  out  1  the last run was aborted by timeout.

## Operation
Transfers are indexed t = 0..N, where N = 1 + DUMMY_BYTES + DATA_BYTES. A 6-bit index register is sufficient.
- t=0: txbyte 00, assert 0. This is a preamble that guarantees CS is deasserted.
- t=1: txbyte FLASH_COMMAND, assert 1.
- t=2..1+DUMMY_BYTES: txbyte 00, assert 1.
- t=2+DUMMY_BYTES..N: txbyte 00. assert is 1 for every data byte except t=N, which has assert 0 so CS releases after the last byte.

Capture rule: the receive byte of transfer t-1 is sampled when ready is seen before issuing transfer t, for t ≥ 3+DUMMY_BYTES. The receive byte of transfer N is sampled at the final poll. Exactly DATA_BYTES captures occur per run.

Reduction, with b = the captured byte and R = id_data:
- FOLD_MODE=1: R <= {R[W-9:0], R[W-1:W-8] ^ b}.
- FOLD_MODE=0: R <= {R[W-9:0], b}.
- The first captured byte enters the least-significant byte lane and ends up most-significant after W/8 captures.

FSM states and transitions:
- IDLE
  - Goes to WAIT on start, or on the first cycle after reset when AUTOSTART=1.
  - On entry to a run: index <= 0, R <= 0, id_valid <= 0, id_error <= 0, timeout counter <= 0.
- WAIT
  - Polls ready. The timeout counter increments each cycle.
  - If ready=1: capture if the rule applies.
    - If index ≤ N, go to WRITE.
    - Otherwise (index = N+1, the final poll), go to DONE.
  - If the counter reaches TIMEOUT_CYCLES: id_error <= 1, go to IDLE. No write is issued and R is left as-is.
- WRITE
  - flash_write=1 for exactly one cycle with flash_writedata for the current index.
  - Then index++, counter <= 0, go to GAP.
- GAP
  - One cycle in which ready is ignored, covering the peripheral's ready deassert latency. Then go to WAIT.
- DONE
  - id_valid <= 1, go to IDLE.

Register and output behaviour:
- busy = (state != IDLE).
- flash_writedata is held at its final value outside WRITE; only flash_write qualifies it.

Reset values:
- flash_write 0; flash_writedata {22'b0, 1, 0, 00}.
- busy 0, id_data 0, id_valid 0, id_error 0.
- State IDLE, index 0.

Boundary conditions:
- start while busy: ignored, no queuing.
- start in the same cycle DONE is entered: ignored, because the FSM is not yet IDLE.
- Reset mid-sequence: immediate return to reset values. CS is recovered on the next run by the t=0 preamble.
- DUMMY_BYTES=0: the command is followed directly by data bytes.
- DATA_BYTES=1: t=N is the only data byte and carries assert 0.
- DATA_BYTES > OUT_WIDTH/8 in FOLD_MODE=0: the oldest bytes are shifted out.

## Timing
- Per byte: minimum 3 cycles (WAIT with ready already high, WRITE, GAP).
- Consecutive flash_write pulses are at least 3 cycles apart.
- Ready is never sampled in a WRITE or GAP cycle.
- id_valid rises 2 cycles after the cycle in which the final ready is sampled (WAIT→DONE, then the register update). busy falls in the same cycle id_valid rises.
- With AUTOSTART and ready held high: N+1 writes, then valid. Total = 3(N+1) + 3 cycles after reset release.
- Timeout: id_error rises TIMEOUT_CYCLES+1 cycles after entering WAIT. busy falls in the same cycle.
- id_data changes only on capture cycles. It is stable while id_valid=1 until the next start is accepted.

## Test plan
- Defaults, peripheral model with ready=1 and data bytes 01..10 → 22 writes in order:
  - 0x200, then 0x34B, then 0x300 ×19, then 0x200.
  - id_data = 0x0808080808080818, id_valid=1, id_error=0.
- Same stimulus with FOLD_MODE=0 → id_data = 0x090A0B0C0D0E0F10.
- TIMEOUT_CYCLES=16, ready stuck at 0 after transfer 5 → id_error=1 after 17 cycles in WAIT, busy=0, no further writes. A subsequent start re-runs from the 0x200 preamble and completes with valid.
- start pulsed at mid-run transfer 8 → ignored; write count stays 22. start after valid → id_valid drops the next cycle and a new identical result is produced.
- Assert reset_sig at transfer 10 → all outputs return to reset values asynchronously. After release with AUTOSTART=1, the sequence restarts at t=0.
- DUMMY_BYTES=0, DATA_BYTES=1, OUT_WIDTH=32, ready=1, data AB → writes 0x200, 0x34B, 0x200; id_data = 0x000000AB.
